// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - register map, bit indices and FSM states for the SPI master
package spi_pkg;

    // Address bits [31:4] of the 16-byte window at 0x0004_0000
    localparam logic [27:0] SPI_BASE_TAG = 28'h0004000;

    // Register word offsets (address_in[3:2])
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DATA   = 2'd2;
    localparam logic [1:0] REG_RSVD   = 2'd3;

    // CTRL bit indices
    localparam int CTRL_CPOL = 8;
    localparam int CTRL_CPHA = 9;
    localparam int CTRL_CS   = 10;
    localparam int CTRL_IE   = 11;

    // STATUS bit indices
    localparam int ST_BUSY   = 0;
    localparam int ST_RXV    = 1;
    localparam int ST_OVR    = 3;
    localparam int ST_COLL   = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } spi_state_e;

endpackage

// File: rtl/spi_shift.sv
// rtl/spi_shift.sv - SCK divider and full-duplex MSB-first byte shift engine
module spi_shift
    import spi_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_start,
    input  logic [7:0] i_tx_byte,
    input  logic [7:0] i_div,
    input  logic       i_cpol,
    input  logic       i_cpha,
    input  logic       i_miso,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_sck,
    output logic       o_mosi,
    output logic [7:0] o_rx_byte
);

    spi_state_e r_state, w_next;
    logic [7:0] r_cnt, r_div, r_tx, r_rx;
    logic [3:0] r_edge;
    logic       r_sck, r_mosi, r_cpha;
    logic       w_wrap, w_leading, w_out_edge, w_smp_edge, w_last;

    // Even-numbered edges (0-based) move SCK away from idle: leading edges
    assign w_wrap     = (r_state == S_SHIFT) && (r_cnt == r_div);
    assign w_leading  = ~r_edge[0];
    assign w_out_edge = w_wrap && (w_leading == r_cpha);
    assign w_smp_edge = w_wrap && (w_leading != r_cpha);
    assign w_last     = w_wrap && (r_edge == 4'd15);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Next-state logic: one byte is 16 SCK edges, then a single DONE cycle
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_next = S_SHIFT;
            S_SHIFT: if (w_last)  w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: latch settings at start, then divide, toggle SCK and shift
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt  <= 8'd0;
            r_div  <= 8'd0;
            r_tx   <= 8'd0;
            r_rx   <= 8'd0;
            r_edge <= 4'd0;
            r_sck  <= 1'b0;
            r_mosi <= 1'b0;
            r_cpha <= 1'b0;
        end else if (r_state == S_IDLE && i_start) begin
            r_div  <= i_div;
            r_cpha <= i_cpha;
            r_sck  <= i_cpol;
            r_cnt  <= 8'd0;
            r_edge <= 4'd0;
            // cpha=0 needs bit 7 on the line before the first (sampling) edge
            if (!i_cpha) begin
                r_mosi <= i_tx_byte[7];
                r_tx   <= {i_tx_byte[6:0], 1'b0};
            end else begin
                r_tx   <= i_tx_byte;
            end
        end else if (r_state == S_SHIFT) begin
            r_cnt <= w_wrap ? 8'd0 : r_cnt + 8'd1;
            if (w_wrap) begin
                r_sck  <= ~r_sck;
                r_edge <= r_edge + 4'd1;
            end
            if (w_out_edge) begin
                r_mosi <= r_tx[7];
                r_tx   <= {r_tx[6:0], 1'b0};
            end
            if (w_smp_edge) r_rx <= {r_rx[6:0], i_miso};
        end
    end

    assign o_busy    = (r_state != S_IDLE);
    assign o_done    = (r_state == S_DONE);
    assign o_sck     = r_sck;
    assign o_mosi    = r_mosi;
    assign o_rx_byte = r_rx;

endmodule

// File: rtl/spi_master.sv
// rtl/spi_master.sv - bus-mapped SPI master; SPI_IRQ_EN adds irq_out and CTRL.ie
module spi_master
    import spi_pkg::*;
#(
    parameter logic [7:0] DIV_RESET = 8'd3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] address_in,
    input  logic        sel_in,
    input  logic        read_in,
    output logic [31:0] read_value_out,
    input  logic [3:0]  write_mask_in,
    input  logic [31:0] write_value_in,
    output logic        ready_out,
    output logic        sck_out,
    output logic        csn_out,
    output logic        mosi_out,
    input  logic        miso_in
`ifdef SPI_IRQ_EN
    ,
    output logic        irq_out
`endif
);

    logic [7:0]  r_div, r_rx_byte;
    logic        r_cpol, r_cpha, r_cs;
    logic        r_rx_valid, r_ovr, r_coll;
    logic        w_hit, w_wr, w_rd, w_ie;
    logic [1:0]  w_reg;
    logic        w_data_wr, w_data_rd, w_start, w_collide, w_set_ovr;
    logic        w_st_w1c, w_ctrl_lo, w_ctrl_hi;
    logic        w_busy, w_done, w_sck, w_mosi;
    logic [7:0]  w_rx;
    logic [31:0] w_rdata;
    logic        w_unused;

    assign w_hit     = sel_in && (address_in[31:4] == SPI_BASE_TAG);
    assign w_reg     = address_in[3:2];
    assign w_wr      = w_hit && (write_mask_in != 4'b0000);
    assign w_rd      = w_hit && read_in;
    assign w_data_wr = w_wr && (w_reg == REG_DATA) && write_mask_in[0];
    assign w_data_rd = w_rd && (w_reg == REG_DATA);
    assign w_start   = w_data_wr && !w_busy;
    assign w_collide = w_data_wr && w_busy;
    assign w_st_w1c  = w_wr && (w_reg == REG_STATUS) && write_mask_in[0];
    assign w_ctrl_lo = w_wr && (w_reg == REG_CTRL) && write_mask_in[0];
    assign w_ctrl_hi = w_wr && (w_reg == REG_CTRL) && write_mask_in[1];
    // A DATA read landing on the DONE cycle loses to DONE and is not an overrun
    assign w_set_ovr = w_done && r_rx_valid && !w_data_rd;
    assign w_unused  = ^{address_in[1:0], write_value_in[31:11]};

    spi_shift u_shift (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_start   (w_start),
        .i_tx_byte (write_value_in[7:0]),
        .i_div     (r_div),
        .i_cpol    (r_cpol),
        .i_cpha    (r_cpha),
        .i_miso    (miso_in),
        .o_busy    (w_busy),
        .o_done    (w_done),
        .o_sck     (w_sck),
        .o_mosi    (w_mosi),
        .o_rx_byte (w_rx)
    );

    // CTRL register, byte-lane masked; the engine latches div/cpol/cpha only at start
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div  <= DIV_RESET;
            r_cpol <= 1'b0;
            r_cpha <= 1'b0;
            r_cs   <= 1'b0;
        end else begin
            if (w_ctrl_lo) r_div <= write_value_in[7:0];
            if (w_ctrl_hi) begin
                r_cpol <= write_value_in[CTRL_CPOL];
                r_cpha <= write_value_in[CTRL_CPHA];
                r_cs   <= write_value_in[CTRL_CS];
            end
        end
    end

    // Receive byte and status flags; set events win over clears
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_byte  <= 8'd0;
            r_rx_valid <= 1'b0;
            r_ovr      <= 1'b0;
            r_coll     <= 1'b0;
        end else begin
            if (w_done) r_rx_byte <= w_rx;
            if (w_done)         r_rx_valid <= 1'b1;
            else if (w_data_rd) r_rx_valid <= 1'b0;
            if (w_set_ovr)                              r_ovr <= 1'b1;
            else if (w_st_w1c && write_value_in[ST_OVR]) r_ovr <= 1'b0;
            if (w_collide)                               r_coll <= 1'b1;
            else if (w_st_w1c && write_value_in[ST_COLL]) r_coll <= 1'b0;
        end
    end

`ifdef SPI_IRQ_EN
    logic r_ie, r_irq;

    // Interrupt enable and registered interrupt request
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ie  <= 1'b0;
            r_irq <= 1'b0;
        end else begin
            if (w_ctrl_hi) r_ie <= write_value_in[CTRL_IE];
            r_irq <= r_ie && (r_rx_valid || r_ovr);
        end
    end

    assign w_ie    = r_ie;
    assign irq_out = r_irq;
`else
    assign w_ie = 1'b0;
`endif

    // Register read mux; output is forced to zero when not selected for OR-combining
    always_comb begin
        w_rdata = 32'd0;
        case (w_reg)
            REG_CTRL:   w_rdata = {20'd0, w_ie, r_cs, r_cpha, r_cpol, r_div};
            REG_STATUS: w_rdata = {27'd0, r_coll, r_ovr, 1'b0, r_rx_valid, w_busy};
            REG_DATA:   w_rdata = {24'd0, r_rx_byte};
            default:    w_rdata = 32'd0;
        endcase
    end

    assign read_value_out = w_hit ? w_rdata : 32'd0;
    assign ready_out      = sel_in;
    assign sck_out        = w_busy ? w_sck : r_cpol;
    assign csn_out        = ~r_cs;
    assign mosi_out       = w_mosi;

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - self-checking bench for spi_master (SPI_IRQ_EN optional)
module tb_spi_master;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] address_in = 32'd0;
    logic        sel_in = 1'b0;
    logic        read_in = 1'b0;
    logic [31:0] read_value_out;
    logic [3:0]  write_mask_in = 4'd0;
    logic [31:0] write_value_in = 32'd0;
    logic        ready_out, sck_out, csn_out, mosi_out, miso_in;
`ifdef SPI_IRQ_EN
    logic        irq_out;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Slave model state
    logic       loop   = 1'b0;
    logic       s_arm  = 1'b0;
    logic       s_cpol = 1'b0;
    logic       s_cpha = 1'b0;
    int         s_div  = 0;
    logic [7:0] s_byte = 8'd0;
    logic [7:0] s_sr = 8'd0;
    logic [7:0] s_rx = 8'd0;
    logic       s_prev = 1'b0;
    int         s_edges = 0;
    int         s_last = 0;
    int         s_bad = 0;

    logic [7:0] exp_q[$];

    typedef struct {
        logic       cpol;
        logic       cpha;
        logic [7:0] div;
        logic [7:0] tx;
        logic [7:0] sb;
    } vec_t;
    vec_t vecs[6];

    assign miso_in = loop ? mosi_out : s_sr[7];

    spi_master #(.DIV_RESET(8'd3)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .address_in     (address_in),
        .sel_in         (sel_in),
        .read_in        (read_in),
        .read_value_out (read_value_out),
        .write_mask_in  (write_mask_in),
        .write_value_in (write_value_in),
        .ready_out      (ready_out),
        .sck_out        (sck_out),
        .csn_out        (csn_out),
        .mosi_out       (mosi_out),
        .miso_in        (miso_in)
`ifdef SPI_IRQ_EN
        ,
        .irq_out        (irq_out)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // SPI slave: samples mosi on its sample edge, advances miso on every trailing edge,
    // and checks that consecutive SCK edges are div+1 clocks apart
    always @(negedge clk) begin
        if (s_arm) begin
            s_sr    <= s_byte;
            s_rx    <= 8'd0;
            s_prev  <= sck_out;
            s_edges <= 0;
            s_bad   <= 0;
            s_last  <= cyc;
        end else if (sck_out !== s_prev) begin
            s_prev  <= sck_out;
            s_edges <= s_edges + 1;
            s_last  <= cyc;
            if (s_edges != 0 && (cyc - s_last) != s_div + 1) s_bad <= s_bad + 1;
            if ((s_prev == s_cpol) != s_cpha) s_rx <= {s_rx[6:0], mosi_out};
            if (s_prev != s_cpol) s_sr <= {s_sr[6:0], 1'b0};
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [3:0] off, input logic [31:0] d, input logic [3:0] m);
        @(negedge clk);
        address_in     = 32'h0004_0000 | {28'd0, off};
        sel_in         = 1'b1;
        read_in        = 1'b0;
        write_mask_in  = m;
        write_value_in = d;
        @(negedge clk);
        sel_in         = 1'b0;
        write_mask_in  = 4'd0;
        write_value_in = 32'd0;
        address_in     = 32'd0;
    endtask

    task automatic bus_read(input logic [3:0] off, output logic [31:0] d);
        @(negedge clk);
        address_in = 32'h0004_0000 | {28'd0, off};
        sel_in     = 1'b1;
        read_in    = 1'b1;
        #1;
        d = read_value_out;
        check("ready_out", {31'd0, ready_out}, 32'd1);
        @(posedge clk);
        #1;
        sel_in     = 1'b0;
        read_in    = 1'b0;
        address_in = 32'd0;
    endtask

    task automatic read_check(input string name, input logic [3:0] off, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(off, d);
        check(name, d, exp);
    endtask

    // Hold a STATUS read and count cycles with busy set; bounded
    task automatic wait_idle(output int busy_cycles);
        logic done;
        done        = 1'b0;
        busy_cycles = 0;
        address_in  = 32'h0004_0004;
        sel_in      = 1'b1;
        read_in     = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            #1;
            if (read_value_out[0]) busy_cycles++;
            else begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        sel_in  = 1'b0;
        read_in = 1'b0;
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL busy_timeout: still busy after 4000 cycles");
        end
    endtask

    task automatic xfer(input logic [7:0] tx, input logic [7:0] exp_rx, input int exp_busy, input string tag);
        int b;
        exp_q.push_back(exp_rx);
        bus_write(4'h8, {24'd0, tx}, 4'h1);
        wait_idle(b);
        check({tag, " busy_cycles"}, b, exp_busy);
    endtask

    task automatic pop_data(input string tag);
        logic [31:0] d;
        logic [7:0]  e;
        bus_read(4'h8, d);
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected nothing (scoreboard empty)", tag, d);
        end else begin
            e = exp_q.pop_front();
            check(tag, d, {24'd0, e});
        end
    endtask

    task automatic arm(input logic cpol, input logic cpha, input int div, input logic [7:0] sb);
        s_cpol = cpol;
        s_cpha = cpha;
        s_div  = div;
        s_byte = sb;
        @(posedge clk);
        s_arm = 1'b1;
        @(posedge clk);
        s_arm = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{cpol: 1'b0, cpha: 1'b0, div: 8'd0, tx: 8'hA5, sb: 8'h5A};
        vecs[1] = '{cpol: 1'b1, cpha: 1'b1, div: 8'd2, tx: 8'h81, sb: 8'h3C};
        vecs[2] = '{cpol: 1'b0, cpha: 1'b1, div: 8'd1, tx: 8'hC3, sb: 8'h96};
        vecs[3] = '{cpol: 1'b1, cpha: 1'b0, div: 8'd3, tx: 8'h7E, sb: 8'h01};
        vecs[4] = '{cpol: 1'b0, cpha: 1'b0, div: 8'd5, tx: 8'h00, sb: 8'hFF};
        vecs[5] = '{cpol: 1'b1, cpha: 1'b1, div: 8'd0, tx: 8'hFF, sb: 8'h80};

        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Reset values
        #1;
        check("rst csn_out", {31'd0, csn_out}, 32'd1);
        check("rst sck_out", {31'd0, sck_out}, 32'd0);
        check("rst mosi_out", {31'd0, mosi_out}, 32'd0);
        read_check("rst CTRL", 4'h0, 32'h0000_0003);
        read_check("rst STATUS", 4'h4, 32'h0);
        read_check("rst DATA", 4'h8, 32'h0);

        // Mode 0 loopback, div=0
        loop = 1'b1;
        bus_write(4'h0, 32'h0000_0400, 4'h3);
        check("cs csn_out", {31'd0, csn_out}, 32'd0);
        xfer(8'hA5, 8'hA5, 17, "loop");
        read_check("loop STATUS rx_valid", 4'h4, 32'h2);
        pop_data("loop DATA");
        read_check("loop STATUS cleared", 4'h4, 32'h0);

        // Overrun: two transfers without reading DATA
        xfer(8'h11, 8'h11, 17, "ovr1");
        xfer(8'h22, 8'h22, 17, "ovr2");
        read_check("ovr STATUS", 4'h4, 32'hA);
        bus_write(4'h4, 32'h8, 4'h1);
        read_check("ovr W1C STATUS", 4'h4, 32'h2);
        void'(exp_q.pop_front());
        pop_data("ovr DATA 2nd byte");

        // Collision while busy; CTRL.cs applies immediately mid-transfer
        bus_write(4'h0, 32'h0000_0401, 4'h3);
        exp_q.push_back(8'h5C);
        bus_write(4'h8, 32'h5C, 4'h1);
        bus_write(4'h8, 32'hFF, 4'h1);
        read_check("coll STATUS busy", 4'h4, 32'h11);
        bus_write(4'h0, 32'h0000_0001, 4'h3);
        check("cs drop csn_out", {31'd0, csn_out}, 32'd1);
        begin
            int b;
            wait_idle(b);
        end
        read_check("coll STATUS idle", 4'h4, 32'h12);
        pop_data("coll DATA unaffected");
        bus_write(4'h4, 32'h10, 4'h1);
        read_check("coll W1C STATUS", 4'h4, 32'h0);
        loop = 1'b0;

        // Table of modes/dividers against the slave model
        for (int i = 0; i < 6; i++) begin
            string t;
            t = $sformatf("vec%0d", i);
            bus_write(4'h0, {21'd0, 1'b1, vecs[i].cpha, vecs[i].cpol, vecs[i].div}, 4'h3);
            arm(vecs[i].cpol, vecs[i].cpha, int'(vecs[i].div), vecs[i].sb);
            xfer(vecs[i].tx, vecs[i].sb, 16 * (int'(vecs[i].div) + 1) + 1, t);
            check({t, " sck idle"}, {31'd0, sck_out}, {31'd0, vecs[i].cpol});
            check({t, " sck edges"}, s_edges, 16);
            check({t, " half-period errors"}, s_bad, 0);
            check({t, " slave rx (mosi)"}, {24'd0, s_rx}, {24'd0, vecs[i].tx});
            read_check({t, " STATUS"}, 4'h4, 32'h2);
            pop_data({t, " DATA"});
        end

        // Reset mid-transfer with cpol=1
        bus_write(4'h0, 32'h0000_0503, 4'h3);
        bus_write(4'h8, 32'h96, 4'h1);
        repeat (10) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst csn_out", {31'd0, csn_out}, 32'd1);
        check("midrst sck_out", {31'd0, sck_out}, 32'd0);
        check("midrst mosi_out", {31'd0, mosi_out}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        read_check("midrst CTRL", 4'h0, 32'h3);
        read_check("midrst STATUS", 4'h4, 32'h0);
        read_check("midrst DATA", 4'h8, 32'h0);

        // Bus corners: byte-lane mask, reserved word, non-selected read
        bus_write(4'h0, 32'hFFFF_FFFF, 4'h2);
`ifdef SPI_IRQ_EN
        read_check("CTRL lane1 only", 4'h0, 32'h0000_0F03);
`else
        read_check("CTRL lane1 only", 4'h0, 32'h0000_0703);
`endif
        bus_write(4'hC, 32'hFFFF_FFFF, 4'hF);
        read_check("RSVD reads 0", 4'hC, 32'h0);
        @(negedge clk);
        address_in = 32'h0004_0000;
        read_in    = 1'b1;
        sel_in     = 1'b0;
        #1;
        check("unsel read_value_out", read_value_out, 32'h0);
        check("unsel ready_out", {31'd0, ready_out}, 32'd0);
        read_in    = 1'b0;
        address_in = 32'd0;

`ifdef SPI_IRQ_EN
        // Interrupt on rx_valid, cleared by DATA read
        loop = 1'b1;
        bus_write(4'h0, 32'h0000_0C00, 4'h3);
        xfer(8'h3A, 8'h3A, 17, "irq");
        @(negedge clk);
        #1;
        check("irq set", {31'd0, irq_out}, 32'd1);
        pop_data("irq DATA");
        repeat (2) @(negedge clk);
        #1;
        check("irq cleared", {31'd0, irq_out}, 32'd0);
        loop = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
